// File: rtl/ysyx_23060136_bht_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_23060136_bht_pkg : shared BHT counter/update types and helpers
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ysyx_23060136_bht_pkg;

   // The update index field is sized for the largest supported table
   localparam int BHT_MAX_ENTRIES = 64;
   localparam int BHT_IDX_W       = $clog2(BHT_MAX_ENTRIES);

   typedef logic [1:0] bht_cnt_t;

   localparam bht_cnt_t CNT_SNT = 2'b00;
   localparam bht_cnt_t CNT_WNT = 2'b01;
   localparam bht_cnt_t CNT_WT  = 2'b10;
   localparam bht_cnt_t CNT_ST  = 2'b11;

   typedef struct packed {
      logic [BHT_IDX_W-1:0] idx;
      logic                 taken;
   } bht_upd_t;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } bht_state_e;

   function automatic bht_cnt_t sat_inc(input bht_cnt_t c);
      return (c == CNT_ST) ? c : c + 2'b01;
   endfunction

   function automatic bht_cnt_t sat_dec(input bht_cnt_t c);
      return (c == CNT_SNT) ? c : c - 2'b01;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_23060136_bht_upd_fifo.sv
// ----------------------------------------------------------------------------
// ysyx_23060136_bht_upd_fifo : synchronous FIFO of pending BHT updates
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ysyx_23060136_bht_upd_fifo
   import ysyx_23060136_bht_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  bht_upd_t                 data_i,
   output bht_upd_t                 data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);

   bht_upd_t       mem_q [DEPTH];
   logic [AW:0]    wr_q;
   logic [AW:0]    rd_q;
   logic           w_push_ok;

   // A push into a full FIFO still fits when the head leaves this cycle
   assign w_push_ok = push_i && (!full_o || pop_i);

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign level_o = wr_q - rd_q;
   assign data_o  = mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (w_push_ok) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
            wr_q                <= wr_q + 1'b1;
         end
         if (pop_i && !empty_o) begin
            rd_q <= rd_q + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/ysyx_23060136_bht_ctrl.sv
// ----------------------------------------------------------------------------
// ysyx_23060136_bht_ctrl : 2-bit BHT with lookup bypass and queued RMW updates
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ysyx_23060136_bht_ctrl
   import ysyx_23060136_bht_pkg::*;
#(
   parameter int       BITS_W    = 32,
   parameter int       ENTRIES   = 64,
   parameter int       UPD_DEPTH = 4,
   parameter bht_cnt_t INIT_CNT  = CNT_WNT
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [BITS_W-1:0]            ifu_pc,
   output logic                         ifu_pre_take,
   input  logic [BITS_W-1:0]            exu_pc,
   input  logic                         exu_pre_take,
   input  logic                         exu_pre_true,
   input  logic                         exu_pre_false,
   input  logic                         exu_stall,
   output logic                         init_busy,
   output logic                         upd_drop,
   output logic [$clog2(UPD_DEPTH):0]   q_level
);

   localparam int IDX_W = $clog2(ENTRIES);

   bht_state_e       state_q;
   logic [IDX_W-1:0] sweep_q;
   logic             drop_q;
   bht_cnt_t         bht_q [ENTRIES];

   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   bht_upd_t         w_push_data;
   bht_upd_t         w_head;
   logic [IDX_W-1:0] w_head_idx;
   logic [IDX_W-1:0] w_look_idx;
   logic [IDX_W-1:0] w_exu_idx;
   bht_cnt_t         w_new_cnt;
   logic             w_unused_pc;

   assign w_look_idx  = ifu_pc[IDX_W+1:2];
   assign w_exu_idx   = exu_pc[IDX_W+1:2];
   assign w_unused_pc = ^{ifu_pc[BITS_W-1:IDX_W+2], ifu_pc[1:0],
                          exu_pc[BITS_W-1:IDX_W+2], exu_pc[1:0]};

   assign w_push      = !exu_stall && (exu_pre_true || exu_pre_false);
   assign w_push_data = '{idx: BHT_IDX_W'(w_exu_idx), taken: exu_pre_take ^ exu_pre_false};
   assign w_pop       = (state_q == RUN) && !w_empty;
   assign w_head_idx  = w_head.idx[IDX_W-1:0];
   assign w_new_cnt   = w_head.taken ? sat_inc(bht_q[w_head_idx]) : sat_dec(bht_q[w_head_idx]);

   ysyx_23060136_bht_upd_fifo #(
      .DEPTH (UPD_DEPTH)
   ) u_upd_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (w_push),
      .pop_i   (w_pop),
      .data_i  (w_push_data),
      .data_o  (w_head),
      .full_o  (w_full),
      .empty_o (w_empty),
      .level_o (q_level)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= INIT;
         sweep_q <= '0;
         drop_q  <= 1'b0;
      end else begin
         drop_q <= w_push && w_full && !w_pop;
         if (state_q == INIT) begin
            sweep_q <= sweep_q + 1'b1;
            if (sweep_q == IDX_W'(ENTRIES - 1)) begin
               state_q <= RUN;
            end
         end
      end
   end

   // Counters need no reset of their own: the sweep rewrites every entry
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == INIT) begin
            bht_q[sweep_q] <= INIT_CNT;
         end else if (w_pop) begin
            bht_q[w_head_idx] <= w_new_cnt;
         end
      end
   end

   always_comb begin
      ifu_pre_take = 1'b0;
      if (state_q == RUN) begin
         if (w_pop && (w_head_idx == w_look_idx)) begin
            ifu_pre_take = w_new_cnt[1];
         end else begin
            ifu_pre_take = bht_q[w_look_idx][1];
         end
      end
   end

   assign init_busy = (state_q == INIT);
   assign upd_drop  = drop_q;

   always_ff @(posedge clk) begin
      if (!rst && !exu_stall) begin
         assert (!(exu_pre_true && exu_pre_false));
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060136_bht_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ysyx_23060136_bht_ctrl : scoreboard bench against a queue/array BHT model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ysyx_23060136_bht_ctrl;

   localparam int ENT   = 64;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ifu_pc;
   logic        ifu_pre_take;
   logic [31:0] exu_pc;
   logic        exu_pre_take;
   logic        exu_pre_true;
   logic        exu_pre_false;
   logic        exu_stall;
   logic        init_busy;
   logic        upd_drop;
   logic [2:0]  q_level;

   ysyx_23060136_bht_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .ifu_pc        (ifu_pc),
      .ifu_pre_take  (ifu_pre_take),
      .exu_pc        (exu_pc),
      .exu_pre_take  (exu_pre_take),
      .exu_pre_true  (exu_pre_true),
      .exu_pre_false (exu_pre_false),
      .exu_stall     (exu_stall),
      .init_busy     (init_busy),
      .upd_drop      (upd_drop),
      .q_level       (q_level)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit busy;
      bit take;
      int lvl;
      bit drop;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errs   = 0;

   // Reference model: counter values, pending updates as idx*2+taken
   int   cnt [ENT];
   int   mq[$];
   int   m_sweep = 0;
   bit   m_drop  = 0;

   task automatic chk(input string name, input int act, input int want);
      n_checks++;
      if (act != want) begin
         n_errs++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, want, $time);
      end
   endtask

   // Monitor: one expectation per non-reset cycle, sampled mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("init_busy",    int'(init_busy),    int'(e.busy));
            chk("ifu_pre_take", int'(ifu_pre_take), int'(e.take));
            chk("q_level",      int'(q_level),      e.lvl);
            chk("upd_drop",     int'(upd_drop),     int'(e.drop));
         end
      end
   end

   task automatic step(input bit r, input bit [31:0] lpc, input bit [31:0] epc,
                       input bit tk, input bit tr, input bit fl, input bit st);
      exp_t e;
      int   lidx, hidx, hnew;
      bit   pop, full;
      rst = r; ifu_pc = lpc; exu_pc = epc;
      exu_pre_take = tk; exu_pre_true = tr; exu_pre_false = fl; exu_stall = st;
      hidx = 0; hnew = 0;
      if (r) begin
         m_sweep = 0; mq.delete(); m_drop = 0;
      end else begin
         e.busy = (m_sweep < ENT);
         e.lvl  = mq.size();
         e.drop = m_drop;
         lidx   = int'((lpc >> 2) % ENT);
         pop    = !e.busy && (mq.size() > 0);
         if (pop) begin
            hidx = mq[0] / 2;
            if (mq[0] % 2 == 1) hnew = (cnt[hidx] == 3) ? 3 : cnt[hidx] + 1;
            else                hnew = (cnt[hidx] == 0) ? 0 : cnt[hidx] - 1;
         end
         if (e.busy)                     e.take = 1'b0;
         else if (pop && hidx == lidx)   e.take = (hnew >= 2);
         else                            e.take = (cnt[lidx] >= 2);
         exp_q.push_back(e);
         full = (mq.size() == DEPTH);
         if (e.busy) begin
            cnt[m_sweep] = 1;
            m_sweep++;
         end else if (pop) begin
            cnt[hidx] = hnew;
            void'(mq.pop_front());
         end
         m_drop = 1'b0;
         if (!st && (tr || fl)) begin
            if (!full || pop) mq.push_back(int'((epc >> 2) % ENT) * 2 + int'(tk ^ fl));
            else              m_drop = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input bit [31:0] lpc);
      step(1'b0, lpc, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   function automatic bit [31:0] rnd_pc();
      return ($urandom & 32'hFFFF_F000) | (($urandom % 6) << 2) | 32'h0000_0010;
   endfunction

   task automatic rand_cycles(input int n);
      int kind;
      for (int i = 0; i < n; i++) begin
         kind = $urandom % 4;
         step(1'b0, rnd_pc(), rnd_pc(), 1'($urandom), kind == 1, kind == 2,
              ($urandom % 4) == 0);
      end
   endtask

   initial begin
      for (int i = 0; i < ENT; i++) cnt[i] = 0;
      for (int i = 0; i < 3; i++) step(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Five updates during the sweep: the fifth must be dropped
      for (int i = 0; i < 5; i++)
         step(1'b0, 32'(i * 4), 32'h8000_0000 + 32'(i * 4), 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 5; i < ENT; i++) idle(32'(i * 4));
      for (int i = 0; i < 6; i++) idle(32'h8000_0000 + 32'(i * 4));
      for (int i = 0; i < ENT; i++) idle(32'h8000_0000 + 32'(i * 4));

      // Three correct-taken updates to one branch: 01 -> 10 -> 11 -> 11
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 32'h8000_0010, 32'h8000_0010, 1'b1, 1'b1, 1'b0, 1'b0);
         idle(32'h8000_0010);
      end
      idle(32'h8000_0010);

      // Raise idx 6 to 10, then a taken-predicted mispredict drops it to 01
      step(1'b0, 32'h8000_0018, 32'h8000_0018, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(32'h8000_0018);
      step(1'b0, 32'h8000_0018, 32'h8000_0018, 1'b1, 1'b0, 1'b1, 1'b0);
      idle(32'h8000_0018);
      idle(32'h8000_0018);

      // Stalled mispredict is ignored, the unstalled one is queued
      step(1'b0, 32'h8000_0014, 32'h8000_0014, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(32'h8000_0014);
      step(1'b0, 32'h8000_0014, 32'h8000_0014, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(32'h8000_0014);
      idle(32'h8000_0014);

      rand_cycles(400);

      // Reset while the queue drains from 4; pending updates must vanish
      step(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         step(1'b0, 32'h8000_0020, 32'h8000_0020 + 32'(i * 4), 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 4; i < ENT; i++) idle(32'h8000_0020);
      idle(32'h8000_0020);
      idle(32'h8000_0020);
      step(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < ENT + 8; i++) idle(32'h8000_0020 + 32'((i % 4) * 4));

      rand_cycles(60);

      @(negedge clk);
      #1;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ysyx_23060136_bht_ctrl.md
Name: ysyx_23060136_bht_ctrl

Overview:
- Owns the branch history table (BHT) of 2-bit saturating counters.
- Serves the combinational taken/not-taken lookup for the IFU fetch PC.
- Queues resolved-branch outcomes from the EX2 branch unit and drains them one per cycle into the table as read-modify-write operations.
- On reset, sweeps the table to the initial counter value before normal operation.

Parameters:
- BITS_W, 32, PC/data width.
- ENTRIES, 64, number of table counters; power of 2; IDX_W = log2(ENTRIES).
- UPD_DEPTH, 4, update queue depth; power of 2, at least 2.
- INIT_CNT, 2'b01, counter value written by the reset sweep (weakly not-taken).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ifu_pc  in  BITS_W  fetch PC for lookup.
- ifu_pre_take  out  1  prediction for ifu_pc; 1 = taken.
- exu_pc  in  BITS_W  PC of the resolved B-type branch.
- exu_pre_take  in  1  prediction that branch carried.
- exu_pre_true  in  1  prediction was correct.
- exu_pre_false  in  1  prediction was wrong.
- exu_stall  in  1  EX2 stalled; suppresses enqueue.
- init_busy  out  1  reset sweep in progress.
- upd_drop  out  1  one-cycle pulse: an update was lost because the queue was full.
- q_level  out  log2(UPD_DEPTH)+1  current queue occupancy.

Behaviour:
- Index: idx(pc) = pc[IDX_W+1:2]. No tag.
- Reset: FSM goes to INIT, sweep index = 0, queue cleared. Output reset values: init_busy = 1, upd_drop = 0, q_level = 0, ifu_pre_take = 0.
- INIT state:
  - Writes INIT_CNT to entry sweep_idx each cycle, then increments sweep_idx.
  - After the write to entry ENTRIES-1, moves to RUN; init_busy deasserts in the first RUN cycle.
  - The sweep takes exactly ENTRIES cycles.
  - ifu_pre_take is forced to 0 throughout INIT.
- Enqueue:
  - Accept when !exu_stall and (exu_pre_true | exu_pre_false).
  - exu_pre_true and exu_pre_false both high is illegal; assert-check it.
  - Entry stored: {idx, taken}, where taken = exu_pre_take ^ exu_pre_false.
  - Enqueue is accepted in INIT too, but the queue does not drain until RUN.
- Full:
  - Full without a same-cycle dequeue: the request is dropped and upd_drop pulses in the following cycle.
  - Full with a same-cycle dequeue: the request is accepted.
- Dequeue (RUN, queue not empty), one per cycle:
  - Read cnt = table[head.idx].
  - Write the new counter in the same cycle: taken ? sat_inc(cnt) : sat_dec(cnt).
  - Saturate at 2'b11 and 2'b00; never wrap.
  - Pop head.
- Latency: an update enqueued in cycle N is written in cycle N+1 at the earliest (empty queue, RUN).
- Back-to-back updates to the same index read the already-written value (flop array, write visible next cycle), so no coalescing is needed.
- Lookup:
  - ifu_pre_take = MSB of table[idx(ifu_pc)], combinational.
  - Write bypass: if the dequeue write index equals idx(ifu_pc) in the same cycle, return the MSB of the new counter value.
- q_level is registered and reflects occupancy after the cycle's enqueue/dequeue.
- Reset asserted mid-sweep or mid-drain: all pending updates are discarded and the sweep restarts from 0.
- Queue pointers wrap modulo UPD_DEPTH. Full/empty are distinguished by an extra pointer bit.

Decomposition:
- Shared package holds:
  - the bht_cnt_t 2-bit typedef;
  - the bht_upd_t struct {idx, taken};
  - constants CNT_SNT = 00, CNT_WNT = 01, CNT_WT = 10, CNT_ST = 11;
  - FSM enum {INIT, RUN};
  - sat_inc/sat_dec functions.
- One sub-module: ysyx_23060136_bht_upd_fifo, a parametrised synchronous FIFO (push/pop/full/empty/level) holding bht_upd_t.
- Counter array, sweep and bypass logic stay in the top module.

Test Plan:
- Reset release with ENTRIES = 64 -> init_busy high for exactly 64 cycles; ifu_pre_take = 0 at every idx; afterwards every entry = 01.
- Three correct-taken updates to pc 0x80000010 (exu_pre_take = 1, exu_pre_true = 1) -> counter sequence 01→10→11→11 (saturates); ifu_pre_take = 1 from the cycle the first write lands.
- Mispredict with exu_pre_take = 1, exu_pre_false = 1 on an entry at 10 -> taken = 0, entry becomes 01, ifu_pre_take falls to 0 in the write cycle via bypass.
- Five updates enqueued during INIT (UPD_DEPTH = 4) -> fifth dropped, upd_drop pulses once, q_level = 4; all four drain in the first four RUN cycles.
- exu_stall = 1 with exu_pre_false = 1 -> no enqueue, q_level unchanged; same stimulus with stall = 0 -> enqueued.
- rst pulsed with q_level = 3 mid-drain -> q_level = 0, init_busy = 1, sweep restarts at index 0, no stale writes after the sweep.
